icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC and a slow backing instruction memory.
- Replaces the zero-latency instruction ROM in the IF stage.
- Hits return the instruction combinationally in the same cycle.
- Misses assert a stall, which the hazard logic ORs into StallF/StallD, while an FSM refills one line word-by-word over a req/ack handshake.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch valid this cycle.
- cpu_addr  in  32  byte address of the fetch (PCF); bits [1:0] are ignored.
- cpu_instr  out  32  instruction word; valid when cpu_req && !cpu_stall.
- cpu_stall  out  1  fetch not satisfied this cycle.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory read request.
- mem_addr  out  32  word-aligned backing address.
- mem_ack  in  1  mem_rdata valid; legal only while mem_req=1, may be high in the same cycle mem_req rises.
- mem_rdata  in  32  returned word.

Behaviour:
- Address split, byte offset OB = 2+log2(WORDS), IB = log2(LINES):
  - word = addr[OB-1:2]
  - index = addr[OB+IB-1:OB]
  - tag = addr[31:OB+IB]
- Storage:
  - valid[LINES], reset to 0.
  - tag array.
  - data array of LINES×WORDS words; not reset.
- hit = cpu_req && valid[index] && tag[index]==tag; combinational.
- cpu_instr = data[index][word] when hit, else 0.
- cpu_stall = cpu_req && (!hit || state!=IDLE); combinational.
- cpu_req=0 → cpu_stall=0, no refill started.
- FSM states IDLE, REFILL.
  - IDLE:
    - Miss (cpu_req && !hit) → latch miss tag and index into refill registers, word_cnt=0, flush_pend=0; next state REFILL.
    - The miss cycle itself issues nothing.
  - REFILL:
    - mem_req=1 (registered as a state decode, no glitch); mem_addr={miss_tag, miss_index, word_cnt, 2'b00}.
    - On mem_ack: data[miss_index][word_cnt] ← mem_rdata; word_cnt++.
    - When word_cnt==WORDS-1 and mem_ack: tag[miss_index] ← miss_tag; valid[miss_index] ← !flush_pend && !flush; next state IDLE.
    - mem_addr holds stable until ack; it advances in the cycle after each ack.
- Refill order is always word 0..WORDS-1; there is no critical-word-first.
- Zero-wait memory (ack whenever req): miss penalty is 1+WORDS stall cycles; the first hit lands on cycle 1+WORDS after the miss cycle.
- cpu_addr may change during REFILL; the refill completes for the latched line regardless. The CPU holds PCF under stall, so the re-lookup hits.
- Outputs in IDLE: mem_req=0, mem_addr=0.
- Flush:
  - In IDLE: all valid bits clear at the next edge.
  - A flush coincident with a hit cycle still returns that cycle's hit data.
  - During REFILL: all valid bits clear and flush_pend=1. The refill runs to completion (the handshake is never abandoned), but the refilled line is left invalid.
- Reset, including mid-REFILL: state=IDLE, mem_req=0 from the next cycle, valid all 0, word_cnt=0, flush_pend=0. Any ack arriving after reset is ignored.
- mem_ack while mem_req=0: ignored.

Decomposition:
- Shared package icache_pkg holds:
  - the state enum (IDLE, REFILL);
  - width-derivation functions (index, offset and tag widths from LINES/WORDS);
  - the field-extract helpers.
- One sub-module, icache_data_ram: LINES×WORDS×32 storage with a combinational read port (index, word) and a synchronous write port (index, word, data, we).
- Tags, valid bits and the FSM remain in icache_direct.

Test Plan:
All scenarios use LINES=16, WORDS=4, so index=addr[7:4] and tag=addr[31:8].
- Cold miss, zero-wait memory, cpu_addr=0x0000_0040:
  - cpu_stall=1 for exactly 5 cycles.
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - 6th cycle: hit, cpu_instr = word returned for 0x40.
- After the refill, fetch 0x44, 0x48, 0x4C:
  - stall=0 each cycle, data matches the memory model.
  - mem_req stays 0.
- Conflict:
  - Fetch 0x140 (index 4, tag 1) → miss and refill; then fetch 0x40 → miss again (eviction).
  - Memory ack latency 2 cycles per word → stall=1 for 1+4×3 = 13 cycles.
- Flush during REFILL after the second ack:
  - The refill still issues all 4 addresses.
  - The line ends invalid; the re-lookup of 0x40 misses and refills again.
- rst pulsed during the third word of a refill:
  - Next cycle mem_req=0 and cpu_stall=0 with cpu_req=0.
  - A late mem_ack is ignored.
  - A subsequent fetch of 0x40 is a full miss.
- cpu_req=0 with cpu_addr=0x80 on a cold cache → cpu_stall=0, mem_req=0, no state change.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state type, width derivation and address field helpers for the icache
package icache_pkg;

  typedef enum logic {
    IDLE,
    REFILL
  } cacheStateT;

  function automatic int indexWidth(input int lines);
    return $clog2(lines);
  endfunction

  // Byte offset of the index field: 2 byte-select bits plus the word-select bits.
  function automatic int offsetWidth(input int words);
    return 2 + $clog2(words);
  endfunction

  function automatic int tagWidth(input int lines, input int words);
    return 32 - offsetWidth(words) - indexWidth(lines);
  endfunction

  function automatic logic [31:0] wordField(input logic [31:0] addr, input int words);
    return (addr >> 2) & 32'(words - 1);
  endfunction

  function automatic logic [31:0] indexField(input logic [31:0] addr, input int lines,
                                             input int words);
    return (addr >> offsetWidth(words)) & 32'(lines - 1);
  endfunction

  function automatic logic [31:0] tagField(input logic [31:0] addr, input int lines,
                                           input int words);
    return addr >> (offsetWidth(words) + indexWidth(lines));
  endfunction

endpackage

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and backing-memory signals of the instruction cache
interface icache_direct_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    output cpu_instr, cpu_stall, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    input  cpu_instr, cpu_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - LINES x WORDS instruction storage, async read and clocked write
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                          clk,
  input  logic [indexWidth(LINES)-1:0]  rdIndex,
  input  logic [$clog2(WORDS)-1:0]      rdWord,
  output logic [31:0]                   rdData,
  input  logic                          we,
  input  logic [indexWidth(LINES)-1:0]  wrIndex,
  input  logic [$clog2(WORDS)-1:0]      wrWord,
  input  logic [31:0]                   wrData
);

  localparam int IW = indexWidth(LINES);
  localparam int WW = $clog2(WORDS);

  logic [31:0] store [LINES*WORDS];

  // Line-major layout so {index, word} is the flat address.
  assign rdData = store[{rdIndex, rdWord}];

  always_ff @(posedge clk) begin
    if (we) begin
      store[{wrIndex, wrWord}] <= wrData;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with word-by-word line refill
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  icache_direct_if.slave  bus
);

  localparam int IW = indexWidth(LINES);
  localparam int WW = $clog2(WORDS);
  localparam int TW = tagWidth(LINES, WORDS);

  logic [IW-1:0] lookupIndex;
  logic [WW-1:0] lookupWord;
  logic [TW-1:0] lookupTag;

  cacheStateT    state;
  logic [TW-1:0] missTag;
  logic [IW-1:0] missIndex;
  logic [WW-1:0] wordCnt;
  logic          flushPend;
  logic          memReq;
  logic [31:0]   memAddr;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tagArr [LINES];

  logic          hit;
  logic          fillWe;
  logic          lastWord;
  logic [31:0]   ramData;

  assign lookupIndex = IW'(indexField(bus.cpu_addr, LINES, WORDS));
  assign lookupWord  = WW'(wordField(bus.cpu_addr, WORDS));
  assign lookupTag   = TW'(tagField(bus.cpu_addr, LINES, WORDS));

  assign hit           = bus.cpu_req && valid[lookupIndex] && (tagArr[lookupIndex] == lookupTag);
  assign bus.cpu_instr = hit ? ramData : 32'h0;
  assign bus.cpu_stall = bus.cpu_req && (!hit || (state != IDLE));
  assign bus.mem_req   = memReq;
  assign bus.mem_addr  = memAddr;

  assign lastWord = (wordCnt == WW'(WORDS - 1));
  assign fillWe   = (state == REFILL) && bus.mem_ack && !rst;

  icache_data_ram #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) dataRam (
    .clk     (clk),
    .rdIndex (lookupIndex),
    .rdWord  (lookupWord),
    .rdData  (ramData),
    .we      (fillWe),
    .wrIndex (missIndex),
    .wrWord  (wordCnt),
    .wrData  (bus.mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      memReq    <= 1'b0;
      memAddr   <= 32'h0;
      valid     <= '0;
      wordCnt   <= '0;
      flushPend <= 1'b0;
      missTag   <= '0;
      missIndex <= '0;
    end else begin
      if (bus.flush) begin
        valid <= '0;
      end
      case (state)
        IDLE: begin
          if (bus.cpu_req && !hit) begin
            missTag   <= lookupTag;
            missIndex <= lookupIndex;
            wordCnt   <= '0;
            flushPend <= 1'b0;
            memReq    <= 1'b1;
            memAddr   <= {lookupTag, lookupIndex, WW'(0), 2'b00};
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush) begin
            flushPend <= 1'b1;
          end
          if (bus.mem_ack) begin
            if (lastWord) begin
              // A flush seen at any point of the refill leaves the line invalid.
              tagArr[missIndex] <= missTag;
              valid[missIndex]  <= !flushPend && !bus.flush;
              wordCnt           <= '0;
              memReq            <= 1'b0;
              memAddr           <= 32'h0;
              state             <= IDLE;
            end else begin
              wordCnt <= wordCnt + WW'(1);
              memAddr <= {missTag, missIndex, wordCnt + WW'(1), 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct with a latency-configurable memory
module tb_icache_direct;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        expStall;
    logic [31:0] expInstr;
    logic        expMemReq;
  } vecT;

  logic clk = 1'b0;
  logic rst;
  logic modelAck;
  logic forceAck;
  int   lat;
  int   nChecks = 0;
  int   nFail = 0;
  int   ackSeen = 0;
  logic [31:0] addrQ[$];
  logic [31:0] instrQ[$];
  vecT  vecs[7];

  always #5 clk = ~clk;

  icache_direct_if bus ();

  assign bus.mem_ack = modelAck | forceAck;

  icache_direct #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushLine(input logic [31:0] base);
    for (int i = 0; i < 4; i++) addrQ.push_back(base + 32'(4 * i));
  endtask

  // Holds the fetch until the cache stops stalling; returns the number of stalled cycles.
  task automatic fetch(input logic [31:0] a, input int budget, output int stalls);
    logic [31:0] expInstr;
    bit timedOut;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    instrQ.push_back(memWord({a[31:2], 2'b00}));
    stalls   = 0;
    timedOut = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      stalls++;
      if (stalls > budget) begin
        timedOut = 1;
        break;
      end
      @(posedge clk); #1;
    end
    expInstr = instrQ.pop_front();
    if (timedOut) begin
      nChecks++;
      nFail++;
      $display("FAIL fetchTimeout: addr 0x%08h still stalled after %0d cycles", a, budget);
    end else begin
      check("fetchInstr", bus.cpu_instr, expInstr);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic applyVec(input vecT v, input int n);
    bus.cpu_req  = v.req;
    bus.cpu_addr = v.addr;
    @(negedge clk);
    check($sformatf("vec%0d_stall", n), 32'(bus.cpu_stall), 32'(v.expStall));
    check($sformatf("vec%0d_instr", n), bus.cpu_instr, v.expInstr);
    check($sformatf("vec%0d_memReq", n), 32'(bus.mem_req), 32'(v.expMemReq));
    @(posedge clk); #1;
  endtask

  task automatic waitAcks(input int target, input int budget);
    int n = 0;
    while (ackSeen < target) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        nChecks++;
        nFail++;
        $display("FAIL ackTimeout: saw %0d acks, needed %0d", ackSeen, target);
        break;
      end
    end
  endtask

  // Backing memory: acks after `lat` extra cycles per word, scoreboards each acked address.
  initial begin
    int cnt = 0;
    logic reqPrev = 1'b0;
    logic ackPrev = 1'b0;
    modelAck      = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req && reqPrev && !ackPrev) cnt++;
      else cnt = 0;
      modelAck      = bus.mem_req && (cnt >= lat);
      bus.mem_rdata = modelAck ? memWord(bus.mem_addr) : 32'hDEAD_BEEF;
      reqPrev       = bus.mem_req;
      ackPrev       = modelAck;
      @(negedge clk);
      if (bus.mem_ack && bus.mem_req) begin
        ackSeen++;
        if (addrQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpectedReq: mem_addr 0x%08h acked with nothing expected", bus.mem_addr);
        end else begin
          check("memAddr", bus.mem_addr, addrQ.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    vecs[0] = '{1'b0, 32'h80, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h80, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h44, 1'b0, memWord(32'h44), 1'b0};
    vecs[3] = '{1'b1, 32'h48, 1'b0, memWord(32'h48), 1'b0};
    vecs[4] = '{1'b1, 32'h4E, 1'b0, memWord(32'h4C), 1'b0};
    vecs[5] = '{1'b1, 32'h40, 1'b0, memWord(32'h40), 1'b0};
    vecs[6] = '{1'b0, 32'h40, 1'b0, 32'h0, 1'b0};

    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.flush    = 1'b0;
    forceAck     = 1'b0;
    lat          = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rstMemReq", 32'(bus.mem_req), 32'h0);
    check("rstMemAddr", bus.mem_addr, 32'h0);
    check("rstStall", 32'(bus.cpu_stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle fetch port on a cold cache.
    for (int i = 0; i < 2; i++) applyVec(vecs[i], i);

    // Cold miss against zero-wait memory.
    pushLine(32'h40);
    fetch(32'h40, 20, s);
    check("coldStalls", s, 5);
    check("coldQueue", addrQ.size(), 0);
    for (int i = 2; i < 7; i++) applyVec(vecs[i], i);

    // Conflict on index 4 with two wait cycles per word.
    lat = 2;
    pushLine(32'h140);
    fetch(32'h140, 40, s);
    check("conflictStallsA", s, 13);
    pushLine(32'h40);
    fetch(32'h40, 40, s);
    check("conflictStallsB", s, 13);
    check("conflictQueue", addrQ.size(), 0);

    // Flush on a hit cycle still returns data, then the line misses.
    lat          = 0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h40;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flushHitStall", 32'(bus.cpu_stall), 32'h0);
    check("flushHitInstr", bus.cpu_instr, memWord(32'h40));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    pushLine(32'h40);
    @(negedge clk);
    check("flushMissStall", 32'(bus.cpu_stall), 32'h1);
    check("flushMissNoReq", 32'(bus.mem_req), 32'h0);
    @(posedge clk); #1;

    // Flush mid-refill after the second ack; refill must finish but leave the line invalid.
    waitAcks(ackSeen + 2, 20);
    bus.flush   = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      n++;
      if (n > 20) begin
        nChecks++;
        nFail++;
        $display("FAIL refillEndTimeout: mem_req still high after %0d cycles", n);
        break;
      end
    end
    check("flushRefillQueue", addrQ.size(), 0);
    @(posedge clk); #1;
    pushLine(32'h40);
    fetch(32'h40, 20, s);
    check("flushRelookupStalls", s, 5);

    // Reset during the third word of a refill.
    lat = 2;
    addrQ.push_back(32'h140);
    addrQ.push_back(32'h144);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h140;
    waitAcks(ackSeen + 2, 30);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midRstMemReq", 32'(bus.mem_req), 32'h0);
    check("midRstStall", 32'(bus.cpu_stall), 32'h0);
    @(posedge clk); #1;
    forceAck = 1'b1;
    @(negedge clk);
    check("lateAckMemReq", 32'(bus.mem_req), 32'h0);
    @(posedge clk); #1;
    forceAck = 1'b0;
    @(negedge clk);
    check("lateAckIdle", 32'(bus.mem_req), 32'h0);
    check("midRstQueue", addrQ.size(), 0);
    @(posedge clk); #1;
    lat = 0;
    pushLine(32'h40);
    fetch(32'h40, 20, s);
    check("postRstStalls40", s, 5);
    pushLine(32'h140);
    fetch(32'h140, 20, s);
    check("postRstStalls140", s, 5);
    check("finalQueue", addrQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
